uart_rx: RTL and testbench

Serial-to-parallel UART receiver: the stage directly downstream of the top-level two-flop `rx` synchronizer, inside the SoC UART path. It consumes the synchronized serial line, recovers 8N1 frames by mid-bit sampling at a parameterized baud rate, and presents each byte on a valid/ready interface to the bus-side UART register logic. It also flags framing, parity and overrun errors.

---
 rtl/uart_rx.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- serial-to-parallel UART receiver with mid-bit sampling.
// Receives 8N1 frames by default. Define UART_RX_PARITY_EN to receive 8E1
// frames with a live parity_err_o; otherwise parity_err_o is tied low.
// Received bytes are offered on a valid/ready holding register; framing,
// parity and overrun conditions are reported as one-cycle pulses.

module uart_rx #(
  parameter int ClkFreq  = 12000000,
  parameter int BaudRate = 115200
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);

  localparam int ClksPerBit = ClkFreq / BaudRate;
  localparam int HalfBit    = ClksPerBit / 2;
  localparam int CntW       = $clog2(ClksPerBit + 1);

  // Fewer than four clocks per bit leaves no room for a meaningful mid-bit sample.
  if (ClksPerBit < 4) begin : gBadBaud
    $error("uart_rx: ClkFreq/BaudRate must be at least 4 clocks per bit");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]      bitIdx_q, bitIdx_d;
  logic [7:0]      shiftReg_q, shiftReg_d;
  logic [7:0]      dataReg_q, dataReg_d;
  logic            valid_q, valid_d;
  logic            frameErr_q, frameErr_d;
  logic            overrun_q, overrun_d;
  logic            parityMismatch;
  logic            halfBitDone;
  logic            fullBitDone;

  // The counter is cleared on the edge that leaves IDLE or hits a sample
  // point, so it reads one less than the number of cycles elapsed since the
  // reference cycle; the compare values are offset by one to land the sample
  // exactly on the intended cycle.
  assign halfBitDone = (clkCnt_q == CntW'(HalfBit - 1));
  assign fullBitDone = (clkCnt_q == CntW'(ClksPerBit - 1));

`ifdef UART_RX_PARITY_EN
  logic parityBit_q, parityBit_d;
  logic parityErr_q, parityErr_d;

  // Even parity: the eight data bits plus the parity bit must XOR to zero.
  assign parityMismatch = ^{shiftReg_q, parityBit_q};
  assign parity_err_o   = parityErr_q;
`else
  assign parityMismatch = 1'b0;
  assign parity_err_o   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: walk start, data, optional parity and stop bits; park in BREAK on a held-low line.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rx_i) state_d = START;
      end
      START: begin
        if (halfBitDone) state_d = rx_i ? IDLE : DATA;
      end
      DATA: begin
        if (fullBitDone && (bitIdx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (fullBitDone) state_d = STOP;
      end
`endif
      STOP: begin
        if (fullBitDone) state_d = rx_i ? IDLE : BREAK;
      end
      BREAK: begin
        if (rx_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: bit timing, shifting, holding-register handshake and error pulses.
  always_comb begin
    clkCnt_d   = clkCnt_q + CntW'(1);
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    dataReg_d  = dataReg_q;
    valid_d    = valid_q & ~ready_i;
    frameErr_d = 1'b0;
    overrun_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityBit_d = parityBit_q;
    parityErr_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        clkCnt_d = '0;
        bitIdx_d = 3'd0;
      end
      START: begin
        if (halfBitDone) clkCnt_d = '0;
      end
      DATA: begin
        if (fullBitDone) begin
          clkCnt_d   = '0;
          shiftReg_d = {rx_i, shiftReg_q[7:1]};
          bitIdx_d   = bitIdx_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (fullBitDone) begin
          clkCnt_d    = '0;
          parityBit_d = rx_i;
        end
      end
`endif
      STOP: begin
        if (fullBitDone) begin
          clkCnt_d = '0;
          if (!rx_i) begin
            frameErr_d = 1'b1;
          end else if (parityMismatch) begin
`ifdef UART_RX_PARITY_EN
            parityErr_d = 1'b1;
`endif
          end else if (!valid_q || ready_i) begin
            dataReg_d = shiftReg_q;
            valid_d   = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      BREAK: begin
        clkCnt_d = '0;
      end
      default: begin
        clkCnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers; reset clears everything so outputs read zero at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      clkCnt_q    <= '0;
      bitIdx_q    <= 3'd0;
      shiftReg_q  <= 8'h00;
      dataReg_q   <= 8'h00;
      valid_q     <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityBit_q <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      clkCnt_q    <= clkCnt_d;
      bitIdx_q    <= bitIdx_d;
      shiftReg_q  <= shiftReg_d;
      dataReg_q   <= dataReg_d;
      valid_q     <= valid_d;
      frameErr_q  <= frameErr_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parityBit_q <= parityBit_d;
      parityErr_q <= parityErr_d;
`endif
    end
  end

  assign data_o      = dataReg_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frameErr_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx at default parameters (104 clocks/bit).
// Honours UART_RX_PARITY_EN: frames then carry an even-parity bit and the
// parity scenarios are included.

module tb_uart_rx;

  localparam int ClksPerBit = 104;
`ifdef UART_RX_PARITY_EN
  localparam int ExpRise = 1093;
`else
  localparam int ExpRise = 989;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overrun_o;

  int compared   = 0;
  int mismatched = 0;

  int cyc        = 0;
  int frameStart = 0;
  int riseCount  = 0;
  int validHigh  = 0;
  int frameErrs  = 0;
  int overruns   = 0;
  int parityErrs = 0;
  int lastRiseRel = 0;
  logic [7:0] lastRiseData = 8'h00;
  logic validPrev = 1'b0;

  int snapRise, snapHigh, snapFrame, snapOver, snapPar;

  uart_rx dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overrun_o    (overrun_o)
  );

  // 100 MHz-style free-running clock; absolute period is irrelevant to the DUT.
  always #5 clk_i = ~clk_i;

  // Cycle index, advanced on every active edge.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Observe outputs mid-cycle and tally pulses, valid rises and their timing.
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) validHigh++;
    if (valid_o === 1'b1 && validPrev !== 1'b1) begin
      riseCount++;
      lastRiseRel  = cyc - frameStart;
      lastRiseData = data_o;
    end
    validPrev = valid_o;
    if (frame_err_o === 1'b1) frameErrs++;
    if (overrun_o === 1'b1) overruns++;
    if (parity_err_o === 1'b1) parityErrs++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic snapshot();
    snapRise  = riseCount;
    snapHigh  = validHigh;
    snapFrame = frameErrs;
    snapOver  = overruns;
    snapPar   = parityErrs;
  endtask

  // Send one frame; the line is left at the stop-bit level afterwards.
  task automatic applyStimulus(input logic [7:0] b, input logic parBit, input logic stopBit);
    rx_i = 1'b0;
    frameStart = cyc;
    tick(ClksPerBit);
    for (int k = 0; k < 8; k++) begin
      rx_i = b[k];
      tick(ClksPerBit);
    end
`ifdef UART_RX_PARITY_EN
    rx_i = parBit;
    tick(ClksPerBit);
`else
    if (parBit === 1'bx) $display("[TB] unexpected unknown parity argument");
`endif
    rx_i = stopBit;
    tick(ClksPerBit);
  endtask

  initial begin
    reset_i = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b0;
    #2 reset_i = 1'b1;
    tick(3);

    // Reset state
    checkOutput("reset_valid", 32'(valid_o), 32'd0);
    checkOutput("reset_data", 32'(data_o), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err_o), 32'd0);
    checkOutput("reset_parity_err", 32'(parity_err_o), 32'd0);
    checkOutput("reset_overrun", 32'(overrun_o), 32'd0);
    reset_i = 1'b0;
    tick(5);

    // Single byte with consumer always ready
    $display("[TB] single byte 0xA5");
    ready_i = 1'b1;
    snapshot();
    applyStimulus(8'hA5, 1'b0, 1'b1);
    tick(20);
    checkOutput("single_rise_count", 32'(riseCount - snapRise), 32'd1);
    checkOutput("single_rise_cycle", 32'(lastRiseRel), 32'(ExpRise));
    checkOutput("single_data", 32'(lastRiseData), 32'hA5);
    checkOutput("single_valid_width", 32'(validHigh - snapHigh), 32'd1);
    checkOutput("single_errors", 32'((frameErrs - snapFrame) + (overruns - snapOver) + (parityErrs - snapPar)), 32'd0);

    // Backpressure and overrun with back-to-back frames
    $display("[TB] backpressure 0x11 then 0x22");
    ready_i = 1'b0;
    snapshot();
    applyStimulus(8'h11, 1'b0, 1'b1);
    checkOutput("bp_first_valid", 32'(valid_o), 32'd1);
    checkOutput("bp_first_overrun", 32'(overruns - snapOver), 32'd0);
    applyStimulus(8'h22, 1'b0, 1'b1);
    rx_i = 1'b1;
    tick(20);
    checkOutput("bp_held_data", 32'(data_o), 32'h11);
    checkOutput("bp_held_valid", 32'(valid_o), 32'd1);
    checkOutput("bp_rise_count", 32'(riseCount - snapRise), 32'd1);
    checkOutput("bp_overrun_count", 32'(overruns - snapOver), 32'd1);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    checkOutput("bp_valid_after_accept", 32'(valid_o), 32'd0);
    tick(5);
    checkOutput("bp_valid_stays_low", 32'(valid_o), 32'd0);

    // Reset asserted mid-frame clears a held byte immediately
    $display("[TB] reset mid-frame");
    applyStimulus(8'h99, 1'b0, 1'b1);
    rx_i = 1'b1;
    tick(20);
    checkOutput("prereset_valid", 32'(valid_o), 32'd1);
    checkOutput("prereset_data", 32'(data_o), 32'h99);
    rx_i = 1'b0;
    frameStart = cyc;
    tick(ClksPerBit);
    rx_i = 1'b1;
    tick(ClksPerBit);
    rx_i = 1'b0;
    tick(400 - 2 * ClksPerBit);
    reset_i = 1'b1;
    #1;
    checkOutput("midreset_valid", 32'(valid_o), 32'd0);
    checkOutput("midreset_data", 32'(data_o), 32'd0);
    checkOutput("midreset_errs", 32'({frame_err_o, parity_err_o, overrun_o}), 32'd0);
    rx_i = 1'b1;
    tick(3);
    reset_i = 1'b0;
    tick(5);
    ready_i = 1'b1;
    snapshot();
    applyStimulus(8'h3C, 1'b0, 1'b1);
    rx_i = 1'b1;
    tick(20);
    checkOutput("postreset_rise_count", 32'(riseCount - snapRise), 32'd1);
    checkOutput("postreset_data", 32'(lastRiseData), 32'h3C);
    checkOutput("postreset_rise_cycle", 32'(lastRiseRel), 32'(ExpRise));

    // Framing error followed by a long break
    $display("[TB] framing error and break");
    snapshot();
    applyStimulus(8'h55, 1'b0, 1'b0);
    tick(3000);
    rx_i = 1'b1;
    tick(50);
    checkOutput("break_frame_err_count", 32'(frameErrs - snapFrame), 32'd1);
    checkOutput("break_no_valid", 32'(riseCount - snapRise), 32'd0);
    checkOutput("break_no_overrun", 32'(overruns - snapOver), 32'd0);
    snapshot();
    applyStimulus(8'h0F, 1'b0, 1'b1);
    rx_i = 1'b1;
    tick(20);
    checkOutput("afterbreak_rise_count", 32'(riseCount - snapRise), 32'd1);
    checkOutput("afterbreak_data", 32'(lastRiseData), 32'h0F);
    checkOutput("afterbreak_frame_err", 32'(frameErrs - snapFrame), 32'd0);

    // Glitch rejection: short low pulse must not start a frame
    $display("[TB] glitch rejection");
    snapshot();
    rx_i = 1'b0;
    tick(30);
    rx_i = 1'b1;
    tick(300);
    checkOutput("glitch_no_valid", 32'(riseCount - snapRise), 32'd0);
    checkOutput("glitch_no_errors", 32'((frameErrs - snapFrame) + (overruns - snapOver) + (parityErrs - snapPar)), 32'd0);
    applyStimulus(8'hC3, 1'b0, 1'b1);
    rx_i = 1'b1;
    tick(20);
    checkOutput("postglitch_data", 32'(lastRiseData), 32'hC3);
    checkOutput("postglitch_rise_cycle", 32'(lastRiseRel), 32'(ExpRise));

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 has three ones, so the even-parity bit is 1
    $display("[TB] parity good and bad");
    snapshot();
    applyStimulus(8'h07, 1'b1, 1'b1);
    rx_i = 1'b1;
    tick(20);
    checkOutput("parity_good_rise", 32'(riseCount - snapRise), 32'd1);
    checkOutput("parity_good_data", 32'(lastRiseData), 32'h07);
    checkOutput("parity_good_err", 32'(parityErrs - snapPar), 32'd0);
    snapshot();
    applyStimulus(8'h07, 1'b0, 1'b1);
    rx_i = 1'b1;
    tick(20);
    checkOutput("parity_bad_err", 32'(parityErrs - snapPar), 32'd1);
    checkOutput("parity_bad_no_valid", 32'(riseCount - snapRise), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
